div_rem_uns_seq: RTL
====================

# div_rem_uns_seq

Sequential unsigned divider: the inverse of the multiply-add datapath. Given a dividend A and divisor Y, it produces quotient Q and remainder R with A = Q*Y + R and R < Y, one quotient bit per cycle (radix-2 restoring). It sits next to the combinational multiply-add units in the arithmetic library and serves blocks that need division or modulo without a large combinational array. Valid/ready handshakes are used on both sides.

## Interface
- widthA, 16, word width of dividend A and quotient Q (widthA >= widthY)
- widthY, 8, word width of divisor Y and remainder R
- speed, lau_pkg::FAST, performance parameter forwarded to the trial subtractor
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset; one clock, synchronous, active-high
- InValid  in  1  operands A, Y valid
- InReady  out  1  block can accept operands
- A  in  widthA  dividend
- Y  in  widthY  divisor
- OutValid  out  1  Q, R, DivZero valid
- OutReady  in  1  consumer accepts the result
- Q  out  widthA  quotient
- R  out  widthY  remainder
- DivZero  out  1  divisor was zero for this result

## Operation
- States: IDLE, BUSY, DONE (3-state FSM).
- IDLE: InReady=1 and OutValid=0. On InValid&InReady:
  - Y != 0: latch Y, load the quotient/shift register with A, clear the partial remainder (widthY+1 bits) and the step counter, then go to BUSY.
  - Y == 0: set Q = all ones, R = A[widthY-1:0], DivZero=1, then go straight to DONE.
- BUSY: each cycle, shift {rem, quo} left by one, so the MSB of quo enters the rem LSB. Then compute rem − Y as a trial subtraction:
  - Non-negative: rem takes the difference and the quo LSB becomes 1.
  - Negative: rem is unchanged and the quo LSB becomes 0.
  - The counter increments. After step widthA, go to DONE.
- DONE: OutValid=1, and Q, R, DivZero are held stable. On OutReady go to IDLE. InReady=0 here, so there is no overlap between accepting new operands and holding a result.
- InReady=0 in BUSY and DONE. InValid in those states is ignored, and the operands are not sampled.
- Width rules:
  - The partial remainder is widthY+1 bits, which prevents overflow of the shifted value before subtraction.
  - R is the low widthY bits of the final remainder. Its MSB is always 0 at the end.
  - The counter is $clog2(widthA+1) bits.
- DivZero is cleared on every accept with Y != 0.
- Reset values: state IDLE, InReady=1, OutValid=0, Q=0, R=0, DivZero=0, counter=0.
- RST mid-operation (BUSY or DONE): abort, any pending result is lost, and the block is in IDLE the following cycle.
- Edge cases follow the general rules with no special handling:
  - A=0 gives Q=0, R=0.
  - A<Y gives Q=0, R=A.
  - Y=1 gives Q=A, R=0.
  - Max operands must not overflow.

## Timing
- Accept edge t0 → BUSY → steps on edges t0+1 … t0+widthA → OutValid high from cycle after t0+widthA.
- Latency is widthA+1 cycles from accept to first OutValid.
- Divide-by-zero latency is 1 cycle: OutValid is high in the cycle after t0.
- Throughput with OutReady held high is one result per widthA+2 cycles: accept, widthA steps, output handshake.
- Backpressure: OutValid remains high, with outputs unchanged, for any number of cycles until OutReady.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- lau_pkg: add the state enum divstate_e {IDLE, BUSY, DONE}. It reuses the existing speed_e.
- Sub-module div_step_uns (combinational, parameter widthY, speed):
  - Inputs: shifted remainder (widthY+1) and divisor.
  - Outputs: next remainder and quotient bit.
  - Built on the library Add with an inverted divisor and carry-in 1.
- The top level contains the FSM, counter, operand, remainder and quotient registers, and the handshake logic.

## Test plan
- widthA=16, widthY=8, A=1000, Y=7 → OutValid exactly 17 cycles after accept, with Q=142, R=6, DivZero=0.
- A=65535, Y=255 → Q=257, R=0. Also A=65535, Y=1 → Q=65535, R=0.
- A=3, Y=200 → Q=0, R=3. Also A=0, Y=9 → Q=0, R=0.
- A=5, Y=0 → OutValid 1 cycle after accept, with Q=16'hFFFF, R=5, DivZero=1. A following A=10, Y=3 gives Q=3, R=1, DivZero=0.
- Backpressure: hold OutReady low for 5 cycles in DONE → OutValid stays 1 and Q/R remain stable. In the same window, InValid with new operands is ignored (InReady=0). After OutReady, the block returns to IDLE and InReady=1.
- Assert RST for 1 cycle at step 8 of a division → next cycle shows IDLE, OutValid=0, InReady=1, Q=0, R=0. Random A/Y against the reference model A = Q*Y + R with R < Y (10k vectors).

Source files
------------

// File: rtl/lau_pkg.sv
// Shared types for the arithmetic library: performance selector and divider FSM states.
package lau_pkg;

    typedef enum logic {
        SLOW,
        FAST
    } speed_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } divstate_e;

endpackage

// File: rtl/Add.sv
// Library adder: S = A + B + CI, modulo 2**width.
// FAST maps to the tool's adder; SLOW spells out a plain ripple chain.
module Add
    import lau_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter speed_e      speed = FAST
) (
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic             CI,
    output logic [width-1:0] S
);

    generate
        if (speed == FAST) begin : g_fast
            assign S = A + B + width'(CI);
        end else begin : g_ripple
            always_comb begin
                logic c;
                c = CI;
                S = '0;
                for (int unsigned i = 0; i < width; i++) begin
                    S[i] = A[i] ^ B[i] ^ c;
                    c    = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
                end
            end
        end
    endgenerate

endmodule

// File: rtl/div_step_uns.sv
// One radix-2 restoring division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it is non-negative.
module div_step_uns
    import lau_pkg::*;
#(
    parameter int unsigned widthY = 8,
    parameter speed_e      speed  = FAST
) (
    input  logic [widthY:0]   rem_in,
    input  logic [widthY-1:0] y,
    output logic [widthY-1:0] rem_out,
    output logic              qbit
);

    logic [widthY:0] diff;

    Add #(
        .width (widthY + 1),
        .speed (speed)
    ) u_add (
        .A  (rem_in),
        .B  (~{1'b0, y}),
        .CI (1'b1),
        .S  (diff)
    );

    // rem_in <= 2*y-1, so rem_in - y always fits the signed widthY+1 range and
    // the top bit of diff is an exact sign.
    assign qbit    = ~diff[widthY];
    assign rem_out = qbit ? diff[widthY-1:0] : rem_in[widthY-1:0];

endmodule

// File: rtl/div_rem_uns_seq.sv
// Sequential unsigned divider, one quotient bit per cycle (radix-2 restoring),
// with valid/ready handshakes on operands and result.
module div_rem_uns_seq
    import lau_pkg::*;
#(
    parameter int unsigned widthA = 16,
    parameter int unsigned widthY = 8,
    parameter speed_e      speed  = FAST
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              InValid,
    output logic              InReady,
    input  logic [widthA-1:0] A,
    input  logic [widthY-1:0] Y,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [widthA-1:0] Q,
    output logic [widthY-1:0] R,
    output logic              DivZero
);

    localparam int unsigned     CW   = $clog2(widthA + 1);
    localparam logic [CW-1:0]   LAST = CW'(widthA - 1);

    divstate_e         state;
    logic [widthY-1:0] ycur;
    logic [widthY-1:0] rem;
    logic [widthA-1:0] quo;
    logic [CW-1:0]     cnt;
    logic [widthY:0]   shifted;
    logic [widthY-1:0] nrem;
    logic              qbit;

    // The stored remainder is always < Y, so the widthY+1-bit partial remainder
    // only materialises as the shifted trial operand.
    assign shifted = {rem, quo[widthA-1]};

    div_step_uns #(
        .widthY (widthY),
        .speed  (speed)
    ) u_step (
        .rem_in  (shifted),
        .y       (ycur),
        .rem_out (nrem),
        .qbit    (qbit)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            InReady  <= 1'b1;
            OutValid <= 1'b0;
            Q        <= '0;
            R        <= '0;
            DivZero  <= 1'b0;
            cnt      <= '0;
            ycur     <= '0;
            rem      <= '0;
            quo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid && InReady) begin
                        InReady <= 1'b0;
                        if (Y != '0) begin
                            ycur    <= Y;
                            quo     <= A;
                            rem     <= '0;
                            cnt     <= '0;
                            DivZero <= 1'b0;
                            state   <= BUSY;
                        end else begin
                            Q        <= '1;
                            R        <= A[widthY-1:0];
                            DivZero  <= 1'b1;
                            OutValid <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                BUSY: begin
                    rem <= nrem;
                    quo <= {quo[widthA-2:0], qbit};
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        Q        <= {quo[widthA-2:0], qbit};
                        R        <= nrem;
                        OutValid <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (OutReady) begin
                        OutValid <= 1'b0;
                        InReady  <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
